vc_test_nport_rand_delay_mem: RTL and testbench

VC_TEST_NPORT_RAND_DELAY_MEM -- requirements
Module: vc_test_nport_rand_delay_mem

---
 rtl/vc_test_mem_pkg.sv | 46 ++++
 rtl/vc_test_rand_delay_port.sv | 92 +++++++++
 rtl/vc_test_nport_rand_delay_mem.sv | 112 +++++++++++
 tb/tb_vc_test_nport_rand_delay_mem.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_mem_pkg.sv
// Shared message layout, type codes and delay-mode constants for the
// n-port random-delay test memory.
package vc_test_mem_pkg;

    localparam logic c_type_read  = 1'b0;
    localparam logic c_type_write = 1'b1;

    localparam int c_delay_zero  = 0;
    localparam int c_delay_fixed = 1;
    localparam int c_delay_rand  = 2;

    // Request {type, addr, len, data}; response {type, len, data}; data at LSB.
    function automatic int req_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + 2 + data_sz;
    endfunction

    function automatic int resp_sz(input int data_sz);
        return 1 + 2 + data_sz;
    endfunction

    function automatic int req_len_lsb(input int data_sz);
        return data_sz;
    endfunction

    function automatic int req_addr_lsb(input int data_sz);
        return data_sz + 2;
    endfunction

    function automatic int req_type_lsb(input int addr_sz, input int data_sz);
        return data_sz + 2 + addr_sz;
    endfunction

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    // Byte lane touched by the k-th byte of an access; wraps inside the word.
    function automatic logic [1:0] lane_of(input logic [1:0] off, input int k);
        return off + 2'(k);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

endpackage

// File: rtl/vc_test_rand_delay_port.sv
// One requester port: accept-delay counter, per-port LFSR, response FIFO
// and fire generation. Memory access itself lives in the top.
module vc_test_rand_delay_port
    import vc_test_mem_pkg::*;
#(
    parameter int          p_data_sz    = 32,
    parameter int          p_max_delay  = 4,
    parameter int          p_delay_mode = 2,
    parameter int          p_resp_depth = 4,
    parameter logic [31:0] p_seed       = 32'h1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_val_i,
    output logic                          req_rdy_o,
    output logic                          fire_o,
    input  logic                          req_type_i,
    input  logic [1:0]                    req_len_i,
    input  logic [p_data_sz-1:0]          rd_data_i,
    output logic                          resp_val_o,
    input  logic                          resp_rdy_i,
    output logic [resp_sz(p_data_sz)-1:0] resp_msg_o
);
    localparam int          c_resp_sz = resp_sz(p_data_sz);
    localparam int          c_aw      = $clog2(p_resp_depth);
    localparam logic [15:0] c_seed    = (p_seed[15:0] == 16'd0) ? 16'd1 : p_seed[15:0];

    function automatic logic [7:0] draw(input logic [15:0] l);
        if (p_delay_mode == c_delay_zero)
            return 8'd0;
        else if (p_delay_mode == c_delay_fixed)
            return 8'(p_max_delay);
        else
            return 8'(l % 16'(p_max_delay + 1));
    endfunction

    localparam logic [7:0] c_cnt_init = draw(c_seed);

    logic [7:0]           cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [c_aw:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 live_q;
    logic                 full, empty, deq;
    logic [p_data_sz-1:0] resp_data;
    logic [c_resp_sz-1:0] q_mem [p_resp_depth];

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                        (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    // live_q keeps the port closed from reset until the first clock edge after release.
    assign req_rdy_o  = live_q && (cnt_q == 8'd0) && !full;
    assign fire_o     = req_val_i && req_rdy_o;
    assign resp_val_o = !empty;
    assign deq        = resp_val_o && resp_rdy_i;
    assign resp_msg_o = q_mem[rd_ptr_q[c_aw-1:0]];
    assign resp_data  = (req_type_i == c_type_write) ? '0 : rd_data_i;

    always_comb begin
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        wr_ptr_d = wr_ptr_q + {{c_aw{1'b0}}, fire_o};
        rd_ptr_d = rd_ptr_q + {{c_aw{1'b0}}, deq};
        if (fire_o) begin
            lfsr_d = lfsr_next(lfsr_q);
            cnt_d  = draw(lfsr_d);
        end else if (req_val_i && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= c_cnt_init;
            lfsr_q   <= c_seed;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire_o)
            q_mem[wr_ptr_q[c_aw-1:0]] <= {req_type_i, req_len_i, resp_data};
    end

endmodule

// File: rtl/vc_test_nport_rand_delay_mem.sv
// Test memory with p_num_ports independent ports, each with its own random
// accept delay and response queue; the word array is shared.
module vc_test_nport_rand_delay_mem
    import vc_test_mem_pkg::*;
#(
    parameter int          p_num_ports  = 3,
    parameter int          p_mem_sz     = 1 << 20,
    parameter int          p_addr_sz    = 32,
    parameter int          p_data_sz    = 32,
    parameter int          p_max_delay  = 4,
    parameter int          p_delay_mode = 2,
    parameter int          p_resp_depth = 4,
    parameter logic [31:0] p_seed       = 32'h1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [p_num_ports-1:0]                          memreq_val,
    output logic [p_num_ports-1:0]                          memreq_rdy,
    input  logic [p_num_ports*req_sz(p_addr_sz, p_data_sz)-1:0] memreq_msg,
    output logic [p_num_ports-1:0]                          memresp_val,
    input  logic [p_num_ports-1:0]                          memresp_rdy,
    output logic [p_num_ports*resp_sz(p_data_sz)-1:0]       memresp_msg
);
    localparam int c_req_sz  = req_sz(p_addr_sz, p_data_sz);
    localparam int c_resp_sz = resp_sz(p_data_sz);
    localparam int c_idx_w   = $clog2(p_mem_sz) - 2;
    localparam int c_words   = p_mem_sz / 4;

    logic [31:0] m [c_words];

    logic [p_num_ports-1:0] fire;
    logic                   wr_type  [p_num_ports];
    logic [c_idx_w-1:0]     wr_widx  [p_num_ports];
    logic [3:0]             wr_mask  [p_num_ports];
    logic [31:0]            wr_lanes [p_num_ports];

    genvar gi;
    for (gi = 0; gi < p_num_ports; gi++) begin : g_port
        logic [c_req_sz-1:0] req;
        logic                req_type_l;
        logic [1:0]          req_len_l;
        logic [1:0]          req_off_l;
        logic [c_idx_w-1:0]  req_widx_l;
        logic [31:0]         req_data_l;
        logic [31:0]         word;
        logic [31:0]         rd_l;
        logic [31:0]         lanes_l;
        logic [3:0]          mask_l;
        logic                unused_req;

        assign req        = memreq_msg[gi*c_req_sz +: c_req_sz];
        assign req_type_l = req[req_type_lsb(p_addr_sz, p_data_sz)];
        assign req_len_l  = req[req_len_lsb(p_data_sz) +: 2];
        assign req_off_l  = req[req_addr_lsb(p_data_sz) +: 2];
        assign req_widx_l = req[req_addr_lsb(p_data_sz) + 2 +: c_idx_w];
        assign req_data_l = req[31:0];
        // Upper address bits are don't-care by design.
        assign unused_req = ^req;
        assign word       = m[req_widx_l];

        always_comb begin
            mask_l  = '0;
            lanes_l = '0;
            rd_l    = '0;
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < len_bytes(req_len_l)) begin
                    mask_l[lane_of(req_off_l, k)]         = 1'b1;
                    lanes_l[8*lane_of(req_off_l, k) +: 8] = req_data_l[8*k +: 8];
                    rd_l[8*k +: 8] = word[8*lane_of(req_off_l, k) +: 8];
                end
            end
        end

        assign wr_type[gi]  = req_type_l;
        assign wr_widx[gi]  = req_widx_l;
        assign wr_mask[gi]  = mask_l;
        assign wr_lanes[gi] = lanes_l;

        vc_test_rand_delay_port #(
            .p_data_sz    (p_data_sz),
            .p_max_delay  (p_max_delay),
            .p_delay_mode (p_delay_mode),
            .p_resp_depth (p_resp_depth),
            .p_seed       (p_seed + 32'(gi))
        ) u_port (
            .clk        (clk),
            .reset      (reset),
            .req_val_i  (memreq_val[gi]),
            .req_rdy_o  (memreq_rdy[gi]),
            .fire_o     (fire[gi]),
            .req_type_i (req_type_l),
            .req_len_i  (req_len_l),
            .rd_data_i  (rd_l),
            .resp_val_o (memresp_val[gi]),
            .resp_rdy_i (memresp_rdy[gi]),
            .resp_msg_o (memresp_msg[gi*c_resp_sz +: c_resp_sz])
        );
    end

    // Later iterations override earlier ones, so the highest port wins per byte.
    always_ff @(posedge clk) begin
        for (int p = 0; p < p_num_ports; p++) begin
            if (fire[p] && wr_type[p] == c_type_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_mask[p][b])
                        m[wr_widx[p]][8*b +: 8] <= wr_lanes[p][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_test_nport_rand_delay_mem.sv
// Directed bench: three memory instances (zero / fixed / random delay)
// driven by one linear stimulus sequence.
module tb_vc_test_nport_rand_delay_mem;
    localparam int RQ = 67;
    localparam int RS = 35;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [2:0]      a_val, a_rdy, a_rval, a_rrdy;
    logic [3*RQ-1:0] a_msg;
    logic [3*RS-1:0] a_rmsg;
    logic [0:0]      b_val, b_rdy, b_rval, b_rrdy;
    logic [RQ-1:0]   b_msg;
    logic [RS-1:0]   b_rmsg;
    logic [1:0]      c_val, c_rdy, c_rval, c_rrdy;
    logic [2*RQ-1:0] c_msg;
    logic [2*RS-1:0] c_rmsg;

    vc_test_nport_rand_delay_mem #(
        .p_num_ports(3), .p_mem_sz(4096), .p_addr_sz(32), .p_data_sz(32),
        .p_max_delay(4), .p_delay_mode(0), .p_resp_depth(2), .p_seed(32'h1)
    ) u_a (
        .clk(clk), .reset(rst_n),
        .memreq_val(a_val), .memreq_rdy(a_rdy), .memreq_msg(a_msg),
        .memresp_val(a_rval), .memresp_rdy(a_rrdy), .memresp_msg(a_rmsg)
    );

    vc_test_nport_rand_delay_mem #(
        .p_num_ports(1), .p_mem_sz(4096), .p_addr_sz(32), .p_data_sz(32),
        .p_max_delay(3), .p_delay_mode(1), .p_resp_depth(4), .p_seed(32'h1)
    ) u_b (
        .clk(clk), .reset(rst_n),
        .memreq_val(b_val), .memreq_rdy(b_rdy), .memreq_msg(b_msg),
        .memresp_val(b_rval), .memresp_rdy(b_rrdy), .memresp_msg(b_rmsg)
    );

    vc_test_nport_rand_delay_mem #(
        .p_num_ports(2), .p_mem_sz(4096), .p_addr_sz(32), .p_data_sz(32),
        .p_max_delay(4), .p_delay_mode(2), .p_resp_depth(4), .p_seed(32'h5)
    ) u_c (
        .clk(clk), .reset(rst_n),
        .memreq_val(c_val), .memreq_rdy(c_rdy), .memreq_msg(c_msg),
        .memresp_val(c_rval), .memresp_rdy(c_rrdy), .memresp_msg(c_rmsg)
    );

    function automatic logic [RQ-1:0] mk(input logic t, input logic [31:0] addr,
                                         input logic [1:0] len, input logic [31:0] data);
        return {t, addr, len, data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts rdy=0 cycles with val held high until rdy=1, then lets that fire happen.
    task automatic measure(input int sel, input int exp_d, input string tag);
        int   run;
        bit   done;
        logic r;
        run  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            r = (sel == 0) ? b_rdy[0] : c_rdy[1];
            if (r) begin
                check(tag, 64'(run), 64'(exp_d));
                done = 1'b1;
            end else begin
                run++;
            end
            step();
        end
        if (!done) check({tag, "_timeout"}, 64'(run), 64'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_val = '0; a_msg = '0; a_rrdy = 3'b111;
        b_val = '0; b_msg = '0; b_rrdy = 1'b1;
        c_val = '0; c_msg = '0; c_rrdy = 2'b00;
        step(); step();
        check("rst_a_rdy",  64'(a_rdy),  64'd0);
        check("rst_a_rval", 64'(a_rval), 64'd0);
        check("rst_b_rdy",  64'(b_rdy),  64'd0);
        check("rst_c_rdy",  64'(c_rdy),  64'd0);
        rst_n = 1'b1;
        step(); step();
        check("a_rdy_idle", 64'(a_rdy), 64'd7);

        // Port 1 write then read, zero delay
        a_val = 3'b010;
        a_msg[RQ +: RQ] = mk(1'b1, 32'h100, 2'd0, 32'hDEADBEEF);
        check("p1_wr_rdy", 64'(a_rdy[1]), 64'd1);
        step();
        check("p1_wr_val",  64'(a_rval[1]), 64'd1);
        check("p1_wr_resp", 64'(a_rmsg[RS +: RS]), 64'({1'b1, 2'd0, 32'h0}));
        a_msg[RQ +: RQ] = mk(1'b0, 32'h100, 2'd0, 32'h0);
        check("p1_rd_rdy", 64'(a_rdy[1]), 64'd1);
        step();
        check("p1_rd_val",  64'(a_rval[1]), 64'd1);
        check("p1_rd_data", 64'(a_rmsg[RS +: RS]), 64'({1'b0, 2'd0, 32'hDEADBEEF}));
        a_val = 3'b000;
        step();
        check("p1_drained", 64'(a_rval[1]), 64'd0);

        // Subword access with wrap-free offsets
        a_val = 3'b001;
        a_msg[0 +: RQ] = mk(1'b1, 32'h200, 2'd0, 32'hAABBCCDD);
        step();
        a_msg[0 +: RQ] = mk(1'b0, 32'h201, 2'd1, 32'h0);
        step();
        check("p0_rd_b1", 64'(a_rmsg[0 +: RS]), 64'({1'b0, 2'd1, 32'h000000CC}));
        a_msg[0 +: RQ] = mk(1'b1, 32'h202, 2'd2, 32'h00001234);
        step();
        check("p0_wr_len2", 64'(a_rmsg[0 +: RS]), 64'({1'b1, 2'd2, 32'h0}));
        a_msg[0 +: RQ] = mk(1'b0, 32'h200, 2'd0, 32'h0);
        step();
        check("p0_rd_merge", 64'(a_rmsg[0 +: RS]), 64'({1'b0, 2'd0, 32'h1234CCDD}));
        a_val = 3'b000;
        step();

        // Same-cycle writes from ports 0 and 2 while port 1 reads
        a_val = 3'b010;
        a_msg[RQ +: RQ] = mk(1'b1, 32'h40, 2'd0, 32'h0);
        step();
        a_val = 3'b111;
        a_msg[0 +: RQ]    = mk(1'b1, 32'h40, 2'd0, 32'h11111111);
        a_msg[RQ +: RQ]   = mk(1'b0, 32'h40, 2'd0, 32'h0);
        a_msg[2*RQ +: RQ] = mk(1'b1, 32'h40, 2'd0, 32'h22222222);
        step();
        check("same_cyc_rd_old", 64'(a_rmsg[RS +: RS]),   64'({1'b0, 2'd0, 32'h0}));
        check("p2_wr_resp",      64'(a_rmsg[2*RS +: RS]), 64'({1'b1, 2'd0, 32'h0}));
        a_val = 3'b010;
        step();
        check("hi_port_wins", 64'(a_rmsg[RS +: RS]), 64'({1'b0, 2'd0, 32'h22222222}));
        a_val = 3'b000;
        step();

        // Backpressure on port 0 with a 2-entry queue
        a_rrdy = 3'b110;
        a_val  = 3'b001;
        a_msg[0 +: RQ] = mk(1'b0, 32'h100, 2'd0, 32'h0);
        check("bp_rdy0", 64'(a_rdy[0]), 64'd1);
        step();
        a_msg[0 +: RQ] = mk(1'b0, 32'h200, 2'd0, 32'h0);
        check("bp_rdy1", 64'(a_rdy[0]), 64'd1);
        step();
        a_msg[0 +: RQ] = mk(1'b0, 32'h40, 2'd0, 32'h0);
        check("bp_full_rdy", 64'(a_rdy[0]), 64'd0);
        step();
        check("bp_still_full", 64'(a_rdy[0]), 64'd0);
        check("bp_head0", 64'(a_rmsg[0 +: RS]), 64'({1'b0, 2'd0, 32'hDEADBEEF}));
        a_rrdy = 3'b111;
        check("bp_deq_same_cyc", 64'(a_rdy[0]), 64'd0);
        step();
        check("bp_rdy_after_deq", 64'(a_rdy[0]), 64'd1);
        check("bp_head1", 64'(a_rmsg[0 +: RS]), 64'({1'b0, 2'd0, 32'h1234CCDD}));
        step();
        a_val = 3'b000;
        check("bp_head2", 64'(a_rmsg[0 +: RS]), 64'({1'b0, 2'd0, 32'h22222222}));
        step();
        check("bp_empty", 64'(a_rval[0]), 64'd0);

        // Fixed delay of 3
        b_val = 1'b1;
        b_msg = mk(1'b1, 32'h0, 2'd0, 32'h0);
        measure(0, 3, "fix_d1");
        measure(0, 3, "fix_d2");
        measure(0, 3, "fix_d3");
        b_val = 1'b0;

        // Random delay, port 1 seed 6: draws 6,12,24,48 mod 5 = 1,2,4,3
        c_val = 2'b10;
        c_msg[RQ +: RQ] = mk(1'b1, 32'h8, 2'd0, 32'h0);
        measure(1, 1, "rnd_a1");
        measure(1, 2, "rnd_a2");
        c_val = 2'b00;
        check("rnd_q_val", 64'(c_rval[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_val", 64'(c_rval), 64'd0);
        check("rst_mid_rdy", 64'(c_rdy),  64'd0);
        step();
        rst_n = 1'b1;
        step(); step();
        check("rst_keep_empty", 64'(c_rval), 64'd0);
        c_rrdy = 2'b11;
        c_val  = 2'b10;
        measure(1, 1, "rnd_b1");
        measure(1, 2, "rnd_b2");
        measure(1, 4, "rnd_b3");
        measure(1, 3, "rnd_b4");
        c_val = 2'b00;

        // Array contents survive reset
        a_val = 3'b100;
        a_msg[2*RQ +: RQ] = mk(1'b0, 32'h40, 2'd0, 32'h0);
        check("mem_kept_rdy", 64'(a_rdy[2]), 64'd1);
        step();
        check("mem_kept", 64'(a_rmsg[2*RS +: RS]), 64'({1'b0, 2'd0, 32'h22222222}));
        a_val = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
